pu_ctrl: RTL and testbench

PU_CTRL -- requirements
Module: pu_ctrl

---
 rtl/pu_ctrl.sv | 98 +++++++++
 tb/tb_pu_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pu_ctrl.sv
// Sequencer for a neuron processing unit: walks each output neuron through
// multiply, adder-tree settle, result capture and a handshaked result write.
module pu_ctrl #(
  parameter int ADDLAT = 1,
  parameter int CW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] numOut,
  input  logic          resReady,
  output logic          busy,
  output logic          done,
  output logic          inLd,
  output logic          ldM,
  output logic          ldRes,
  output logic [CW-1:0] wSel,
  output logic          resWr,
  output logic [CW-1:0] resAddr
);

  typedef enum logic [2:0] {
    IDLE, INIT, MUL, WAIT, ADD, WRITE, DONE
  } puState;

  localparam logic [2:0] WaitLast = 3'(ADDLAT - 1);

  puState        state, nextState;
  logic [CW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [2:0]    waitCnt;
  logic          lastNeuron;

  // cnt is never zero once a neuron is in flight, so cnt-1 cannot underflow here.
  assign lastNeuron = (idx == cnt - CW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx     <= '0;
      cnt     <= '0;
      waitCnt <= '0;
    end else begin
      case (state)
        INIT: begin
          cnt <= numOut;
          idx <= '0;
        end
        MUL:  waitCnt <= '0;
        WAIT: waitCnt <= waitCnt + 3'd1;
        WRITE: begin
          if (resReady && !lastNeuron) begin
            idx <= idx + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (start) nextState = INIT;
      INIT:  nextState = (numOut == '0) ? DONE : MUL;
      MUL:   nextState = (ADDLAT > 0) ? WAIT : ADD;
      WAIT:  if (waitCnt == WaitLast) nextState = ADD;
      ADD:   nextState = WRITE;
      WRITE: if (resReady) nextState = lastNeuron ? DONE : MUL;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs depend only on registered state and idx, never on inputs.
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    inLd    = (state == INIT);
    ldM     = (state == MUL);
    ldRes   = (state == ADD);
    resWr   = (state == WRITE);
    wSel    = '0;
    resAddr = '0;
    if (state == MUL || state == WAIT || state == ADD || state == WRITE) begin
      wSel    = idx;
      resAddr = idx;
    end
  end

endmodule

// File: tb/tb_pu_ctrl.sv
// Bench for pu_ctrl: two instances (ADDLAT=0 and ADDLAT=1) share stimulus and
// are compared every cycle against a phase-counting reference model.
module tb_pu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] numOut;
  logic       resReady;

  logic       busy0, done0, inLd0, ldM0, ldRes0, resWr0;
  logic [3:0] wSel0, resAddr0;
  logic       busy1, done1, inLd1, ldM1, ldRes1, resWr1;
  logic [3:0] wSel1, resAddr1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: mode 0 idle, 1 init, 2 neuron in flight, 3 done.
  int mMode[2] = '{0, 0};
  int mN[2]    = '{0, 0};
  int mPh[2]   = '{0, 0};
  int mCnt[2]  = '{0, 0};

  pu_ctrl #(.ADDLAT(0), .CW(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .numOut(numOut), .resReady(resReady),
    .busy(busy0), .done(done0), .inLd(inLd0), .ldM(ldM0), .ldRes(ldRes0),
    .wSel(wSel0), .resWr(resWr0), .resAddr(resAddr0)
  );

  pu_ctrl #(.ADDLAT(1), .CW(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .numOut(numOut), .resReady(resReady),
    .busy(busy1), .done(done1), .inLd(inLd1), .ldM(ldM1), .ldRes(ldRes1),
    .wSel(wSel1), .resWr(resWr1), .resAddr(resAddr1)
  );

  always #5 clk = ~clk;

  // Instance k has ADDLAT=k, so a neuron spends phases 0..k+2 (ldM .. write).
  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        mMode[k] = 0; mN[k] = 0; mPh[k] = 0; mCnt[k] = 0;
      end else begin
        case (mMode[k])
          0: if (start) mMode[k] = 1;
          1: begin
            mCnt[k] = int'(numOut);
            mN[k]   = 0;
            mPh[k]  = 0;
            mMode[k] = (mCnt[k] == 0) ? 3 : 2;
          end
          2: begin
            if (mPh[k] < k + 2) mPh[k]++;
            else if (resReady) begin
              if (mN[k] == mCnt[k] - 1) mMode[k] = 3;
              else begin
                mN[k]++;
                mPh[k] = 0;
              end
            end
          end
          default: mMode[k] = 0;
        endcase
      end
    end
  end

  function automatic logic [13:0] expOut(input int k);
    logic b, d, i, m, r, w;
    logic [3:0] a;
    b = (mMode[k] != 0);
    d = (mMode[k] == 3);
    i = (mMode[k] == 1);
    m = 1'b0; r = 1'b0; w = 1'b0; a = 4'd0;
    if (mMode[k] == 2) begin
      m = (mPh[k] == 0);
      r = (mPh[k] == k + 1);
      w = (mPh[k] == k + 2);
      a = 4'(mN[k]);
    end
    return {b, d, i, m, r, w, a, a};
  endfunction

  task automatic checkEq(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [13:0] obs0, obs1, exp0, exp1;
    obs0 = {busy0, done0, inLd0, ldM0, ldRes0, resWr0, wSel0, resAddr0};
    obs1 = {busy1, done1, inLd1, ldM1, ldRes1, resWr1, wSel1, resAddr1};
    exp0 = expOut(0);
    exp1 = expOut(1);
    checks++;
    assert (obs0 === exp0) else begin
      errors++;
      $error("[TB] FAIL out_lat0 cyc=%0d observed=%h expected=%h", cyc, obs0, exp0);
    end
    checks++;
    assert (obs1 === exp1) else begin
      errors++;
      $error("[TB] FAIL out_lat1 cyc=%0d observed=%h expected=%h", cyc, obs1, exp1);
    end
    checkEq("onehot_lat0", ($countones({done0, inLd0, ldM0, ldRes0, resWr0}) <= 1) ? 1 : 0, 1);
    checkEq("onehot_lat1", ($countones({done1, inLd1, ldM1, ldRes1, resWr1}) <= 1) ? 1 : 0, 1);
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] n, input logic rr);
    start    = s;
    numOut   = n;
    resReady = rr;
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    checkOutput();
  endtask

  // Runs one layer from a start pulse until both instances are idle again.
  task automatic runLayer(input int n, input bit noisy, input int reStartAt,
                          output int d0, output int d1, output int n0, output int n1);
    bit finished;
    d0 = -1; d1 = -1; n0 = 0; n1 = 0; finished = 0;
    applyStimulus(1'b1, 4'(n), 1'b1);
    cycle();
    start = 1'b0;
    for (int c = 2; c <= 600; c++) begin
      cycle();
      if (done0) begin n0++; if (d0 < 0) d0 = c; end
      if (done1) begin n1++; if (d1 < 0) d1 = c; end
      if (!busy0 && !busy1) begin
        finished = 1;
        break;
      end
      start = (c == reStartAt) || (noisy && busy0 && busy1 && ($urandom_range(0, 5) == 0));
      if (noisy) begin
        numOut   = 4'($urandom);
        resReady = ($urandom_range(0, 3) != 0);
      end
    end
    start = 1'b0;
    resReady = 1'b1;
    checkEq("layer_finished", int'(finished), 1);
  endtask

  initial begin
    int d0, d1, n0, n1;
    rst = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b1);
    repeat (2) cycle();
    rst = 1'b1;
    cycle();

    runLayer(2, 0, 0, d0, d1, n0, n1);
    checkEq("two_neuron_done_lat1", d1, 10);
    checkEq("two_neuron_done_lat0", d0, 8);
    checkEq("two_neuron_pulses", n0 + n1, 2);

    runLayer(0, 0, 0, d0, d1, n0, n1);
    checkEq("zero_neuron_done_lat0", d0, 2);
    checkEq("zero_neuron_done_lat1", d1, 2);

    // Result sink stalls for several cycles on a single neuron.
    applyStimulus(1'b1, 4'd1, 1'b0);
    cycle();
    start = 1'b0;
    repeat (7) cycle();
    resReady = 1'b1;
    for (int c = 0; c < 20 && (busy0 || busy1); c++) cycle();
    checkEq("stall_idle", int'(busy0 | busy1), 0);

    runLayer(3, 0, 6, d0, d1, n0, n1);
    checkEq("restart_ignored_done_lat1", d1, 14);
    checkEq("restart_ignored_done_lat0", d0, 11);
    checkEq("restart_ignored_pulses_lat0", n0, 1);
    checkEq("restart_ignored_pulses_lat1", n1, 1);

    runLayer(15, 0, 0, d0, d1, n0, n1);
    checkEq("full_layer_done_lat0", d0, 47);
    checkEq("full_layer_done_lat1", d1, 62);

    // Asynchronous reset between clock edges while a layer is in flight.
    applyStimulus(1'b1, 4'd5, 1'b1);
    cycle();
    start = 1'b0;
    repeat (2) cycle();
    #2 rst = 1'b0;
    #1 checkOutput();
    checkEq("async_rst_busy", int'(busy0 | busy1), 0);
    @(negedge clk);
    rst = 1'b1;
    n0 = 0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      n0 += int'(done0) + int'(done1);
    end
    checkEq("no_done_after_reset", n0, 0);

    for (int t = 0; t < 20; t++) begin
      runLayer($urandom_range(0, 15), 1, 0, d0, d1, n0, n1);
      checkEq("random_pulses_lat0", n0, 1);
      checkEq("random_pulses_lat1", n1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
